sram_word_ctrl: RTL and testbench

//  Bridges the multi-cycle MIPS32 32-bit memory port to the 2K x 8 byte-wide SRAM.

---
 rtl/sram_word_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_sram_word_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl - splits 32-bit CPU word accesses into four sequential byte
// accesses on a byte-wide asynchronous SRAM (2^SRAM_AW bytes).
//
// Parameters:
//   SRAM_AW     SRAM byte-address width (word space = 2^(SRAM_AW-2) words)
//   BIG_ENDIAN  1: byte 0 (lowest address) carries bits [31:24]; 0: bits [7:0]
//   RD_WAIT     extra cycles per read byte between issue and capture (0..3)
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   req, wr           access request / direction, sampled only when idle
//   cpu_addr          byte address, bits [SRAM_AW-1:2] select the word
//   cpu_wdata         write word, captured at accept
//   cpu_be            byte enables (only when SRAM_BYTE_MASK_EN is defined)
//   cpu_rdata         last read word, updated in one step when a read completes
//   busy, done        in-progress flag / one-cycle completion pulse
//   sram_nce          chip enable (active low), low only while a strobe is high
//   sram_re, sram_we  read / write strobes, never both high
//   sram_addr         {word index, byte index}
//   sram_data         bidirectional byte bus, driven only while sram_we=1
//
// Optional feature macro: SRAM_BYTE_MASK_EN (byte-masked writes; disabled
// bytes cost no SRAM cycle, an all-zero mask completes immediately).
// All outputs are registered.

module sram_word_ctrl #(
  parameter int unsigned SRAM_AW    = 11,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned RD_WAIT    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               wr,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [3:0]         cpu_be,
`endif
  output logic [31:0]        cpu_rdata,
  output logic               busy,
  output logic               done,
  output logic               sram_nce,
  output logic               sram_re,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  logic [7:0]         sram_data
);

  localparam int unsigned WW = SRAM_AW - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [WW-1:0] word_q, word_d;
  logic [31:0]   wbuf_q, wbuf_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rbuf_q, rbuf_d;
  logic [7:0]    dout_q, dout_d;

  logic [31:0]        rdata_d;
  logic               busy_d, done_d, nce_d, re_d, we_d;
  logic [SRAM_AW-1:0] addr_d;

  logic [3:0] be_in;
  logic [2:0] nxt;
  logic       rd_capture;

`ifdef SRAM_BYTE_MASK_EN
  assign be_in = cpu_be;
`else
  assign be_in = '1;
`endif

  logic unused_addr;
  assign unused_addr = ^{cpu_addr[31:SRAM_AW], cpu_addr[1:0]};

  assign sram_data = sram_we ? dout_q : 'z;

  // Byte k (SRAM address order) lives in lane lane_of(k) of the word.
  function automatic logic [1:0] lane_of(input logic [1:0] k);
    return BIG_ENDIAN ? ~k : k;
  endfunction

  // Lowest byte index >= from whose lane is enabled: {found, index}.
  function automatic logic [2:0] first_en(input logic [3:0] be, input logic [2:0] from);
    logic [2:0] r;
    r = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!r[2] && (3'(k) >= from) && be[lane_of(2'(k))]) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    word_d  = word_q;
    wbuf_d  = wbuf_q;
    be_d    = be_q;
    rbuf_d  = rbuf_q;
    dout_d  = dout_q;
    rdata_d = cpu_rdata;
    busy_d  = busy;
    done_d  = 1'b0;
    nce_d   = 1'b1;
    re_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = sram_addr;
    nxt     = '0;
    // Capture at the edge ending the last cycle of the current read byte.
    rd_capture = (state_q == S_RD_ISSUE) ? (RD_WAIT == 0) : (wcnt_q == 2'd0);

    case (state_q)
      S_IDLE: begin
        if (req) begin
          word_d = cpu_addr[SRAM_AW-1:2];
          wbuf_d = cpu_wdata;
          be_d   = be_in;
          busy_d = 1'b1;
          if (wr) begin
            nxt = first_en(be_in, 3'd0);
            if (nxt[2]) begin
              state_d = S_WR;
              idx_d   = nxt[1:0];
              nce_d   = 1'b0;
              we_d    = 1'b1;
              addr_d  = {cpu_addr[SRAM_AW-1:2], nxt[1:0]};
              dout_d  = cpu_wdata[{lane_of(nxt[1:0]), 3'b000} +: 8];
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            state_d = S_RD_ISSUE;
            idx_d   = 2'd0;
            nce_d   = 1'b0;
            re_d    = 1'b1;
            addr_d  = {cpu_addr[SRAM_AW-1:2], 2'd0};
          end
        end
      end

      S_WR: begin
        nxt = first_en(be_q, {1'b0, idx_q} + 3'd1);
        if (nxt[2]) begin
          idx_d  = nxt[1:0];
          nce_d  = 1'b0;
          we_d   = 1'b1;
          addr_d = {word_q, nxt[1:0]};
          dout_d = wbuf_q[{lane_of(nxt[1:0]), 3'b000} +: 8];
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      S_RD_ISSUE, S_RD_WAIT: begin
        nce_d = 1'b0;
        re_d  = 1'b1;
        if (!rd_capture) begin
          if (state_q == S_RD_ISSUE) begin
            state_d = S_RD_WAIT;
            wcnt_d  = 2'(RD_WAIT - 1);
          end else begin
            wcnt_d = wcnt_q - 2'd1;
          end
        end else begin
          rbuf_d[{lane_of(idx_q), 3'b000} +: 8] = sram_data;
          if (idx_q == 2'd3) begin
            // Whole word published at once, including the byte captured now.
            state_d = S_DONE;
            rdata_d = rbuf_d;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            nce_d   = 1'b1;
            re_d    = 1'b0;
          end else begin
            state_d = S_RD_ISSUE;
            idx_d   = idx_q + 2'd1;
            addr_d  = {word_q, idx_q + 2'd1};
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wcnt_q    <= '0;
      word_q    <= '0;
      wbuf_q    <= '0;
      be_q      <= '0;
      rbuf_q    <= '0;
      dout_q    <= '0;
      cpu_rdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sram_nce  <= 1'b1;
      sram_re   <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      word_q    <= word_d;
      wbuf_q    <= wbuf_d;
      be_q      <= be_d;
      rbuf_q    <= rbuf_d;
      dout_q    <= dout_d;
      cpu_rdata <= rdata_d;
      busy      <= busy_d;
      done      <= done_d;
      sram_nce  <= nce_d;
      sram_re   <= re_d;
      sram_we   <= we_d;
      sram_addr <= addr_d;
    end
  end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Testbench for sram_word_ctrl: behavioural byte SRAM on the bus, a word-level
// reference memory, a vector table, hand-written corner sequences and a
// randomized read/write mix.

module tb_sram_word_ctrl;

  localparam int AW  = 11;
  localparam int RDW = 1;
  localparam bit BE  = 1'b1;
  localparam int WR_LAT = 5;
  localparam int RD_LAT = 4 * (1 + RDW) + 1;

  logic          clk = 1'b0;
  logic          rst_n, req, wr;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          busy, done, sram_nce, sram_re, sram_we;
  logic [AW-1:0] sram_addr;
  wire  [7:0]    sram_data;
`ifdef SRAM_BYTE_MASK_EN
  logic [3:0]    cpu_be;
`endif

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  sram_word_ctrl #(.SRAM_AW(AW), .BIG_ENDIAN(BE), .RD_WAIT(RDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef SRAM_BYTE_MASK_EN
    .cpu_be(cpu_be),
`endif
    .cpu_rdata(cpu_rdata), .busy(busy), .done(done),
    .sram_nce(sram_nce), .sram_re(sram_re), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_data(sram_data)
  );

  // Behavioural asynchronous-read, clocked-write byte SRAM.
  logic [7:0] mem [0:(1<<AW)-1];
  assign sram_data = (!sram_nce && sram_re && !sram_we) ? mem[sram_addr] : 8'bz;
  always @(posedge clk) if (!sram_nce && sram_we) mem[sram_addr] <= sram_data;

  // Word-level reference memory.
  logic [7:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] written_q [$];

  function automatic int byte_addr(input logic [31:0] a, input int k);
    return int'(((a >> 2) % (1 << (AW - 2))) * 4) + k;
  endfunction

  function automatic int shift_of(input int k);
    return BE ? 8 * (3 - k) : 8 * k;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) ref_mem[byte_addr(a, k)] = 8'((d >> shift_of(k)) & 32'hFF);
    written_q.push_back(a);
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) r = r | (32'(ref_mem[byte_addr(a, k)]) << shift_of(k));
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Strobe sanity every cycle once out of reset.
  always @(negedge clk) if (mon_en) chk("strobes", {30'd0, sram_we & sram_re, sram_nce ^ !(sram_we | sram_re)}, 32'd0);

  // One access from idle; returns read word and cycles from accept edge to done.
  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    bit busy_ok = 1'b1;
    @(negedge clk);
    req = 1'b1; wr = w; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
    lat = 1;
    while (!done && lat < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_while_active", 32'(busy_ok), 32'd1);
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    rd = cpu_rdata;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [6];
  logic [31:0] rd, last_rd, a, d;
  int lat;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_0014, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h0000_07FC, 32'h1122_3344, 32'h0};
    tbl[3] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h1122_3344};
    tbl[4] = '{1'b1, 32'h0000_0002, 32'h0102_0304, 32'h0};
    tbl[5] = '{1'b0, 32'hABCD_0801, 32'h0,         32'h0102_0304};

    rst_n = 1'b0; req = 1'b0; wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef SRAM_BYTE_MASK_EN
    cpu_be = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nce", 32'(sram_nce), 32'd1);
    chk("rst_re_we", {30'd0, sram_re, sram_we}, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;

    // Vector table.
    last_rd = '0;
    for (int i = 0; i < 6; i++) begin
      access(tbl[i].w, tbl[i].a, tbl[i].d, rd, lat);
      if (tbl[i].w) begin
        ref_write(tbl[i].a, tbl[i].d);
        chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(WR_LAT));
        chk($sformatf("vec%0d_rdata_held", i), rd, last_rd);
      end else begin
        chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(RD_LAT));
        chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        last_rd = rd;
      end
    end
    chk("mem_0x14", {mem[11'h14], mem[11'h15], mem[11'h16], mem[11'h17]}, 32'hDEAD_BEEF);
    chk("mem_0x7fc", {mem[11'h7FC], mem[11'h7FD], mem[11'h7FE], mem[11'h7FF]}, 32'h1122_3344);

    // req held high across a write: one access, re-accept only after DONE.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("held_lat", 32'(lat), 32'(WR_LAT));
    @(posedge clk); #1;
    chk("held_idle_busy", {30'd0, busy, done}, 32'd0);
    @(posedge clk); #1;
    chk("held_reaccept_busy", 32'(busy), 32'd1);
    req = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("held_second_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    ref_write(32'h30, 32'hCAFE_F00D);
    chk("held_mem", {mem[11'h30], mem[11'h31], mem[11'h32], mem[11'h33]}, 32'hCAFE_F00D);

    // Reset sampled at the edge that would start byte 2 of a write.
    access(1'b1, 32'h40, 32'h5555_5555, rd, lat);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hAABB_CCDD;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_nce", 32'(sram_nce), 32'd1);
    chk("abort_we", 32'(sram_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata", cpu_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    chk("abort_mem", {mem[11'h40], mem[11'h41], mem[11'h42], mem[11'h43]}, 32'hAABB_5555);
    for (int k = 0; k < 4; k++) ref_mem[11'h40 + k] = mem[11'h40 + k];
    last_rd = '0;

`ifdef SRAM_BYTE_MASK_EN
    access(1'b1, 32'h20, 32'h0000_0000, rd, lat);
    ref_write(32'h20, 32'h0);
    cpu_be = 4'b0101;
    access(1'b1, 32'h20, 32'hAABB_CCDD, rd, lat);
    cpu_be = 4'hF;
    ref_write(32'h20, 32'h00BB_00DD);
    chk("mask_lat", 32'(lat), 32'd3);
    chk("mask_mem", {mem[11'h20], mem[11'h21], mem[11'h22], mem[11'h23]}, 32'h00BB_00DD);
`endif

    // Randomized mix; reads target previously written words (any alias).
    for (int i = 0; i < 40; i++) begin
      if (($urandom_range(1, 0) == 1) || written_q.size() == 0) begin
        a = $urandom; d = $urandom;
        access(1'b1, a, d, rd, lat);
        ref_write(a, d);
        chk("rnd_wr_lat", 32'(lat), 32'(WR_LAT));
        chk("rnd_rdata_held", rd, last_rd);
      end else begin
        a = written_q[$urandom_range(written_q.size() - 1, 0)];
        a = {$urandom_range(32'h1F_FFFF, 0), a[AW-1:2], 2'($urandom)};
        access(1'b0, a, $urandom, rd, lat);
        chk("rnd_rd_lat", 32'(lat), 32'(RD_LAT));
        chk("rnd_rdata", rd, ref_read(a));
        last_rd = rd;
      end
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
